// File: rtl/if_stage_fetch_ctrl_if.sv
// Bus between the fetch controller and its surroundings: hazard-unit stall
// controls, ID-stage redirect, instruction memory, and the IF/ID register.
interface if_stage_fetch_ctrl_if;
  // redirect_valid is a one-cycle pulse that is always accepted: there is no
  // back-pressure, so a redirect that cannot be taken at once is held inside the
  // block. imem_ready=1 qualifies imem_rdata in that same cycle. imem_ready=0 is
  // a wait state, and fetch_stall reports it back to the pipeline.
  logic        PCWrite;
  logic        IF_IDWrite;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
  logic        fetch_stall;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic        dbgState;
  logic [31:0] dbgPendTarget;

  modport master (
    output PCWrite, IF_IDWrite, redirect_valid, redirect_target, imem_rdata, imem_ready,
    input  imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, fetch_stall,
           fetch_count, stall_count, dbgState, dbgPendTarget
  );

  modport slave (
    input  PCWrite, IF_IDWrite, redirect_valid, redirect_target, imem_rdata, imem_ready,
    output imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, fetch_stall,
           fetch_count, stall_count, dbgState, dbgPendTarget
  );
endinterface

// File: rtl/if_stage_fetch_ctrl.sv
// RV32i fetch stage: PC register with a held-redirect FSM, the IF/ID pipeline
// register, and fetch/stall event counters.
module if_stage_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic clk,
  input logic reset_n,
  if_stage_fetch_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} fetchState_t;

  fetchState_t state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] pendTarget, pendTargetNext;
  logic [31:0] ifIdPc, ifIdPcNext;
  logic [31:0] ifIdInstr, ifIdInstrNext;
  logic        ifIdValid, ifIdValidNext;
  logic [31:0] fetchCount, stallCount;
  logic        pendValid, pcAdv, redir, loadValid;
  logic [31:0] newTarget, tgt;

  assign pendValid = (state == PEND);
  assign pcAdv     = bus.PCWrite & bus.imem_ready;
  assign redir     = bus.redirect_valid | pendValid;
  assign newTarget = {bus.redirect_target[31:2], 2'b00};
  // A fresh redirect always wins over an older held one.
  assign tgt       = bus.redirect_valid ? newTarget : pendTarget;
  assign loadValid = bus.IF_IDWrite & ~redir & bus.imem_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RUN;
      pc         <= RESET_PC;
      pendTarget <= 32'h0;
    end else begin
      state      <= stateNext;
      pc         <= pcNext;
      pendTarget <= pendTargetNext;
    end
  end

  always_comb begin
    stateNext      = state;
    pcNext         = pc;
    pendTargetNext = pendTarget;
    case (state)
      RUN: begin
        if (bus.redirect_valid) begin
          if (pcAdv) begin
            pcNext = newTarget;
          end else begin
            pendTargetNext = newTarget;
            stateNext      = PEND;
          end
        end else if (pcAdv) begin
          pcNext = pc + 32'd4;
        end
      end
      PEND: begin
        if (pcAdv) begin
          pcNext    = tgt;
          stateNext = RUN;
        end else if (bus.redirect_valid) begin
          pendTargetNext = newTarget;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  // Any redirect in flight squashes the wrong-path word. A bubble keeps the
  // current PC so that IF_ID_pc stays meaningful.
  always_comb begin
    ifIdPcNext    = ifIdPc;
    ifIdInstrNext = ifIdInstr;
    ifIdValidNext = ifIdValid;
    if (bus.IF_IDWrite) begin
      ifIdPcNext = pc;
      if (loadValid) begin
        ifIdInstrNext = bus.imem_rdata;
        ifIdValidNext = 1'b1;
      end else begin
        ifIdInstrNext = NOP_INSTR;
        ifIdValidNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ifIdPc     <= 32'h0;
      ifIdInstr  <= NOP_INSTR;
      ifIdValid  <= 1'b0;
      fetchCount <= 32'h0;
      stallCount <= 32'h0;
    end else begin
      ifIdPc    <= ifIdPcNext;
      ifIdInstr <= ifIdInstrNext;
      ifIdValid <= ifIdValidNext;
      if (loadValid) fetchCount <= fetchCount + 32'd1;
      if (!pcAdv)    stallCount <= stallCount + 32'd1;
    end
  end

  assign bus.imem_addr     = pc;
  assign bus.IF_ID_pc      = ifIdPc;
  assign bus.IF_ID_instr   = ifIdInstr;
  assign bus.IF_ID_valid   = ifIdValid;
  assign bus.fetch_stall   = ~bus.imem_ready;
  assign bus.fetch_count   = fetchCount;
  assign bus.stall_count   = stallCount;
  assign bus.dbgState      = pendValid;
  assign bus.dbgPendTarget = pendTarget;

endmodule

// File: tb/tb_if_stage_fetch_ctrl.sv
// Bench for if_stage_fetch_ctrl: directed vector table, then random traffic
// checked against a rule-level model of the fetch stage.
module tb_if_stage_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  if_stage_fetch_ctrl_if bus ();

  if_stage_fetch_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    logic        rst;
    logic        pw;
    logic        iw;
    logic        rv;
    logic [31:0] rt;
    logic        rdy;
    logic [31:0] ea;
    logic [31:0] ep;
    logic [31:0] ei;
    logic        ev;
    logic [31:0] efc;
    logic [31:0] esc;
    logic        est;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addV(input logic rst, input logic pw, input logic iw, input logic rv,
                      input logic [31:0] rt, input logic rdy, input logic [31:0] ea,
                      input logic [31:0] ep, input logic [31:0] ei, input logic ev,
                      input logic [31:0] efc, input logic [31:0] esc, input logic est);
    vec_t v;
    v.rst = rst; v.pw = pw; v.iw = iw; v.rv = rv; v.rt = rt; v.rdy = rdy;
    v.ea = ea; v.ep = ep; v.ei = ei; v.ev = ev; v.efc = efc; v.esc = esc; v.est = est;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic pw, input logic iw, input logic rv,
                       input logic [31:0] rt, input logic rdy, input logic [31:0] rdata);
    reset_n             = rst;
    bus.PCWrite         = pw;
    bus.IF_IDWrite      = iw;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.imem_ready      = rdy;
    bus.imem_rdata      = rdata;
  endtask

  // Reference model state: architectural view only (PC, held redirect, IF/ID, counters).
  logic [31:0] mPc, mPendTgt, mIfPc, mIfInstr, mFc, mSc;
  logic        mPend, mIfValid;

  task automatic modelStep(input logic rst, input logic pw, input logic iw, input logic rv,
                           input logic [31:0] rt, input logic rdy, input logic [31:0] rdata);
    logic        adv, hasRed;
    logic [31:0] t;
    if (!rst) begin
      mPc = 32'h0; mPend = 1'b0; mPendTgt = 32'h0;
      mIfPc = 32'h0; mIfInstr = NOP; mIfValid = 1'b0; mFc = 32'h0; mSc = 32'h0;
    end else begin
      adv    = pw & rdy;
      hasRed = rv | mPend;
      t      = rv ? (rt & 32'hFFFF_FFFC) : mPendTgt;
      if (iw) begin
        mIfPc = mPc;
        if (!hasRed && rdy) begin
          mIfInstr = rdata; mIfValid = 1'b1; mFc = mFc + 1;
        end else begin
          mIfInstr = NOP; mIfValid = 1'b0;
        end
      end
      if (adv) begin
        mPc   = hasRed ? t : mPc + 32'd4;
        mPend = 1'b0;
      end else begin
        mSc = mSc + 1;
        if (hasRed) begin
          mPend = 1'b1; mPendTgt = t;
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //   rst pw iw rv target        rdy  addr           ifpc           instr          v  fc  sc  st
    addV(0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         NOP,           0, 0,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h4,         32'h0,         32'h1,         1, 1,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h8,         32'h4,         32'h5,         1, 2,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'hC,         32'h8,         32'h9,         1, 3,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h10,        32'hC,         32'hD,         1, 4,  0, 0);
    addV(0, 1, 1, 0, 32'h0,         1, 32'h0,         32'h0,         NOP,           0, 0,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h4,         32'h0,         32'h1,         1, 1,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h8,         32'h4,         32'h5,         1, 2,  0, 0);
    addV(1, 0, 0, 0, 32'h0,         1, 32'h8,         32'h4,         32'h5,         1, 2,  1, 0);
    addV(1, 0, 0, 0, 32'h0,         1, 32'h8,         32'h4,         32'h5,         1, 2,  2, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'hC,         32'h8,         32'h9,         1, 3,  2, 0);
    addV(1, 1, 1, 1, 32'h20,        1, 32'h20,        32'hC,         NOP,           0, 3,  2, 0);
    addV(1, 1, 1, 1, 32'h100,       1, 32'h100,       32'h20,        NOP,           0, 3,  2, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h104,       32'h100,       32'h101,       1, 4,  2, 0);
    addV(1, 1, 1, 1, 32'h200,       0, 32'h104,       32'h104,       NOP,           0, 4,  3, 1);
    addV(1, 1, 1, 0, 32'h0,         0, 32'h104,       32'h104,       NOP,           0, 4,  4, 1);
    addV(1, 1, 1, 0, 32'h0,         0, 32'h104,       32'h104,       NOP,           0, 4,  5, 1);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h200,       32'h104,       NOP,           0, 4,  5, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h204,       32'h200,       32'h201,       1, 5,  5, 0);
    addV(1, 1, 1, 1, 32'h300,       0, 32'h204,       32'h204,       NOP,           0, 5,  6, 1);
    addV(1, 1, 1, 1, 32'h400,       0, 32'h204,       32'h204,       NOP,           0, 5,  7, 1);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h400,       32'h204,       NOP,           0, 5,  7, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h404,       32'h400,       32'h401,       1, 6,  7, 0);
    addV(1, 1, 1, 1, 32'h500,       0, 32'h404,       32'h404,       NOP,           0, 6,  8, 1);
    addV(0, 1, 1, 0, 32'h0,         1, 32'h0,         32'h0,         NOP,           0, 0,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h4,         32'h0,         32'h1,         1, 1,  0, 0);
    addV(1, 1, 1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 32'h4,         NOP,           0, 1,  0, 0);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFD, 1, 2,  0, 0);
    addV(1, 1, 0, 0, 32'h0,         1, 32'h4,         32'hFFFF_FFFC, 32'hFFFF_FFFD, 1, 2,  0, 0);
    addV(1, 0, 0, 1, 32'h600,       1, 32'h4,         32'hFFFF_FFFC, 32'hFFFF_FFFD, 1, 2,  1, 1);
    addV(1, 1, 1, 0, 32'h0,         1, 32'h600,       32'h4,         NOP,           0, 2,  1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pw, vecs[i].iw, vecs[i].rv, vecs[i].rt, vecs[i].rdy,
            bus.imem_addr | 32'h1);
      #1;
      if (vecs[i].rst) chk($sformatf("v%0d fetch_stall", i), {31'h0, bus.fetch_stall}, {31'h0, ~vecs[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d imem_addr", i),   bus.imem_addr,   vecs[i].ea);
      chk($sformatf("v%0d IF_ID_pc", i),    bus.IF_ID_pc,    vecs[i].ep);
      chk($sformatf("v%0d IF_ID_instr", i), bus.IF_ID_instr, vecs[i].ei);
      chk($sformatf("v%0d IF_ID_valid", i), {31'h0, bus.IF_ID_valid}, {31'h0, vecs[i].ev});
      chk($sformatf("v%0d fetch_count", i), bus.fetch_count, vecs[i].efc);
      chk($sformatf("v%0d stall_count", i), bus.stall_count, vecs[i].esc);
      chk($sformatf("v%0d state", i),       {31'h0, bus.dbgState}, {31'h0, vecs[i].est});
    end

    // Random traffic; the first cycle is a reset so the model starts aligned.
    for (int n = 0; n < 600; n++) begin
      logic        rst, pw, iw, rv, rdy;
      logic [31:0] rt, rdata;
      rst   = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      pw    = ($urandom_range(0, 3) != 0);
      iw    = pw ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      rv    = ($urandom_range(0, 3) == 0);
      rt    = $urandom;
      rdy   = ($urandom_range(0, 3) != 0);
      rdata = $urandom;
      drive(rst, pw, iw, rv, rt, rdy, rdata);
      modelStep(rst, pw, iw, rv, rt, rdy, rdata);
      exp_q.push_back(mPc);
      @(posedge clk);
      #1;
      chk("rand imem_addr",   bus.imem_addr,   exp_q.pop_front());
      chk("rand IF_ID_pc",    bus.IF_ID_pc,    mIfPc);
      chk("rand IF_ID_instr", bus.IF_ID_instr, mIfInstr);
      chk("rand IF_ID_valid", {31'h0, bus.IF_ID_valid}, {31'h0, mIfValid});
      chk("rand fetch_count", bus.fetch_count, mFc);
      chk("rand stall_count", bus.stall_count, mSc);
      chk("rand pending",     {31'h0, bus.dbgState}, {31'h0, mPend});
      if (mPend) chk("rand pend_target", bus.dbgPendTarget, mPendTgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage_fetch_ctrl.md
Name: if_stage_fetch_ctrl

Overview:
- Fetch stage of the RV32i pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes the hazard unit's PCWrite/IF_IDWrite stall controls and the ID-stage branch/jump redirect.
- Drives the instruction-memory address and reports instruction-memory wait states back as fetch_stall.
- Holds a pending redirect whenever the PC cannot update in the cycle the redirect arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush or wait

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- PCWrite  input  1  from hazardDetectionUnit; 0 = hold PC.
- IF_IDWrite  input  1  from hazardDetectionUnit; 0 = hold IF/ID register.
- redirect_valid  input  1  ID stage resolved taken branch/JAL/JALR this cycle.
- redirect_target  input  32  target PC, valid with redirect_valid.
- imem_addr  output  32  fetch address; equals current PC (combinational from PC register).
- imem_rdata  input  32  instruction at imem_addr, valid when imem_ready=1.
- imem_ready  input  1  1 = imem_rdata valid this cycle; 0 = wait state.
- IF_ID_pc  output  32  PC of instruction in IF/ID.
- IF_ID_instr  output  32  instruction in IF/ID.
- IF_ID_valid  output  1  0 = bubble.
- fetch_stall  output  1  combinational, equals !imem_ready.
- fetch_count  output  32  number of valid instructions written into IF/ID; wraps.
- stall_count  output  32  number of cycles with PC held (PCWrite=0 or imem_ready=0); wraps.

Behaviour:
- Reset (reset_n=0 at a rising edge) sets:
  - PC=RESET_PC, IF_ID_pc=0, IF_ID_instr=NOP_INSTR, IF_ID_valid=0;
  - pend_valid=0, pend_target=0, state=RUN;
  - fetch_count=0, stall_count=0.
- Reset overrides every other input, including a redirect or a pending redirect mid-flight.
- Definitions:
  - pc_adv = PCWrite & imem_ready.
  - redir = redirect_valid | pend_valid.
  - tgt = redirect_valid ? redirect_target : pend_target. A new redirect overrides an older pending one.
- State machine, 2 states:
  - RUN: no pending redirect.
    - redirect_valid & pc_adv: PC <= redirect_target; stay in RUN.
    - redirect_valid & !pc_adv: pend_target <= redirect_target, pend_valid <= 1; go to PEND.
    - otherwise, if pc_adv: PC <= PC+4.
  - PEND: a redirect is held.
    - pc_adv: PC <= tgt, pend_valid <= 0; go to RUN.
    - !pc_adv: hold PC; update pend_target if redirect_valid; stay in PEND.
- PC arithmetic:
  - 32-bit, wraps modulo 2^32; 32'hFFFF_FFFC+4 = 0.
  - redirect_target bits[1:0] are forced to 0 when loaded.
- IF/ID register, evaluated each cycle:
  - IF_IDWrite=0: hold all three fields, regardless of redirect or imem_ready.
  - IF_IDWrite=1 & redir: bubble (valid=0, instr=NOP_INSTR, pc=current PC). The wrong-path instruction is squashed.
  - IF_IDWrite=1 & !redir & imem_ready: load {PC, imem_rdata, valid=1}.
  - IF_IDWrite=1 & !redir & !imem_ready: bubble.
- Latency:
  - Instruction at PC appears on IF_ID_* on the next edge.
  - After a redirect with no stalls: one bubble cycle in IF/ID, then the target instruction appears 2 edges after redirect_valid.
- Counters:
  - fetch_count increments when IF/ID loads valid=1.
  - stall_count increments when pc_adv=0 and reset_n=1.
- PCWrite=1 with IF_IDWrite=0 is not produced by the hazard unit. If it occurs, each register obeys its own enable: PC advances and the fetched instruction is dropped.

Test Plan:
- Reset with RESET_PC=0, then 4 cycles with PCWrite=IF_IDWrite=imem_ready=1 and imem_rdata=PC|1 -> imem_addr 0,4,8,12,16; IF_ID_pc 0,4,8,12 with valid=1; fetch_count=4.
- PCWrite=IF_IDWrite=0 for 2 cycles at PC=8 -> PC holds 8; IF/ID holds {4, 0x5, 1}; stall_count +2; resume -> PC=12.
- redirect_valid=1, target=0x100, at PC=0x20 -> next cycle PC=0x100 and IF/ID bubble (0x13, valid=0); following cycle IF_ID_pc=0x100, valid=1.
- imem_ready=0 for 3 cycles while redirect_valid pulses target=0x200 in the first cycle -> state PEND, PC holds, IF/ID bubbles; first imem_ready=1 cycle loads PC=0x200 and returns to RUN.
- Two redirects during a stall (0x300, then 0x400) -> PC=0x400 on release; 0x300 is never fetched.
- Assert reset_n=0 while in PEND -> PC=RESET_PC, pend cleared, IF_ID_valid=0, both counters 0; PC=0xFFFF_FFFC advancing -> 0x0.
